// File: rtl/otp_stream_cipher.sv
// otp_stream_cipher: one-time-pad style stream cipher.
// A Galois LFSR produces the keystream. Each accepted word is XORed with the
// next DATA_W keystream bits and comes out one cycle later through a
// valid/ready output register. Encrypt and decrypt are the same operation.
// Optional feature macro OTP_REKEY_EN: enforce a MAX_WORDS budget per seed,
// after which the block parks in EXHAUSTED until the next seed_load.
module otp_stream_cipher #(
  parameter int                DATA_W    = 8,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter int                CNT_W     = 16,
  parameter int                MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  key_count,
  output logic              exhausted
);

`ifdef OTP_REKEY_EN
  localparam bit REKEY = 1'b1;
`else
  localparam bit REKEY = 1'b0;
`endif

  localparam logic [CNT_W-1:0] BUDGET = CNT_W'(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    EXHAUSTED = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LFSR_W-1:0] lfsr_p0;
  logic [LFSR_W-1:0] lfsr_adv;
  logic [DATA_W-1:0] ks_word;
  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;
  logic [CNT_W-1:0]  cnt_p1;
  logic [CNT_W-1:0]  cnt_inc;
  logic [LFSR_W-1:0] seed_val;
  logic              accept;
  logic              budget_hit;

  // Run the LFSR DATA_W steps; returns {next state, keystream word}, bit 0 first.
  function automatic logic [LFSR_W+DATA_W-1:0] advance(input logic [LFSR_W-1:0] s_in);
    logic [LFSR_W-1:0] s;
    logic [DATA_W-1:0] ks;
    s  = s_in;
    ks = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ks[i] = s[0];
      s     = (s >> 1) ^ (s[0] ? TAPS : '0);
    end
    return {s, ks};
  endfunction

  // Saturating increment so the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign accept     = in_valid && in_ready;
  assign cnt_inc    = sat_inc(cnt_p1);
  assign budget_hit = (cnt_inc == BUDGET);
  // An all-zero state would lock the LFSR, so zero seeds load 1 instead.
  assign seed_val   = (seed == '0) ? LFSR_W'(1) : seed;

  // Combinational unroll of the keystream for the word being accepted.
  always_comb begin
    {lfsr_adv, ks_word} = advance(lfsr_p0);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: seed_load always wins; the budget only matters with rekeying.
  always_comb begin
    state_nxt = state;
    if (seed_load) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (REKEY && accept && budget_hit) state_nxt = EXHAUSTED;
        default: state_nxt = state;
      endcase
    end
  end

  // FSM outputs: accept only when running, enabled and the output slot frees up.
  always_comb begin
    in_ready  = (state == RUN) && en && !seed_load && (!vld_p1 || out_ready);
    exhausted = REKEY && (state == EXHAUSTED);
  end

  // ---- stage p0 -> p1: keystream XOR into the output register ----
  // Datapath: seed load restarts the stream, accept advances it, drain empties the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_p0 <= '0;
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      cnt_p1  <= '0;
    end else if (seed_load) begin
      lfsr_p0 <= seed_val;
      vld_p1  <= 1'b0;
      cnt_p1  <= '0;
    end else if (accept) begin
      lfsr_p0 <= lfsr_adv;
      data_p1 <= in_data ^ ks_word;
      vld_p1  <= 1'b1;
      cnt_p1  <= cnt_inc;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign key_count = cnt_p1;

endmodule

// File: doc/otp_stream_cipher.md
Name: otp_stream_cipher

Overview:
Parametrised successor to the fixed-width one-time-pad XOR path. An internal Galois LFSR of configurable width and taps generates the keystream. Data words pass through a valid/ready handshake and are XORed with the next DATA_W keystream bits. Encryption and decryption are the same operation, so two instances with the same seed form a matched cipher/decipher pair.

Parameters:
DATA_W, 8, plaintext/ciphertext word width in bits (1..32)
LFSR_W, 16, keystream generator state width (DATA_W..32)
TAPS, 16'hB400, Galois feedback mask, LFSR_W bits
CNT_W, 16, width of the consumed-word counter
MAX_WORDS, 1024, word budget per seed (used only with OTP_REKEY_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  cipher enable; when low, no new words are accepted
seed_load  in  1  one-cycle pulse: load seed, restart the key stream
seed  in  LFSR_W  key seed
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid && in_ready
in_data  in  DATA_W  plaintext or ciphertext
out_valid  out  1  output word valid
out_ready  in  1  downstream ready
out_data  out  DATA_W  in_data XOR keystream word
key_count  out  CNT_W  words consumed since the last seed load
exhausted  out  1  word budget spent (tied 0 without OTP_REKEY_EN)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, lfsr=0, out_valid=0, out_data=0, key_count=0, exhausted=0.
- States: IDLE (unseeded), RUN, EXHAUSTED (only with OTP_REKEY_EN).
- seed_load=1 in any state: on the next edge, state=RUN, lfsr=seed, key_count=0, out_valid=0, exhausted=0.
  - A seed of all zeros loads 1 instead, because an all-zero state would lock the LFSR.
  - seed_load has priority. in_ready=0 during the seed_load cycle, and any pending output word is discarded.
- LFSR step: b=s[0]; s=s>>1; if b then s^=TAPS. The keystream bit is b.
- Keystream word: bit i is the output of step i, with bit 0 produced first. Each accepted word advances the LFSR DATA_W steps in a single cycle (combinational unroll).
- in_ready = (state==RUN) && en && !seed_load && (!out_valid || out_ready).
- On accept:
  - out_data <= in_data ^ keystream on the next edge, and out_valid <= 1. Latency is 1 cycle.
  - key_count increments and saturates at all-ones.
- out_valid falls after an out_ready cycle with no new accept. While out_valid && !out_ready, out_data is held stable.
- Simultaneous accept and drain: a new word replaces the old one with out_valid staying 1, giving full throughput of 1 word/clk.
- en=0: LFSR and key_count are frozen, and a pending output still drains.
- IDLE: in_ready=0, and in_valid is ignored.
- Reset mid-stream: immediate return to IDLE, and any in-flight word is lost.

Optional Feature:
Macro OTP_REKEY_EN.
- Defined: when key_count reaches MAX_WORDS after an accept, the block goes to EXHAUSTED.
  - In EXHAUSTED: exhausted=1, in_ready=0, and the last word still drains.
  - Only seed_load leaves EXHAUSTED. This enforces single use of the pad.
- Undefined: there is no EXHAUSTED state and exhausted is tied 0. The LFSR free-runs, and the key repeats after its period.

Test Plan:
- Reset/idle: reset=0 then 1 with no seed -> in_ready=0, out_valid=0, key_count=0, in_valid=1 ignored.
- Known vector (defaults): seed=16'h0001, send 0x41 then 0x42 with out_ready=1 -> keystream 0x01, 0x68; out_data 0x40 then 0x2A, each one cycle after accept; key_count=2.
- Round trip: cipher output feeds a second instance with the same seed; send the ASCII string "OTP" -> decipher outputs 0x4F, 0x54, 0x50 in order.
- Backpressure:
  - out_ready=0 for 5 cycles with in_valid=1 -> out_data held and in_ready=0 after the first word.
  - Release -> one word per clock and no word lost or duplicated.
- Zero seed and reload: seed=0 -> behaves as seed=1 (first key 0x01). seed_load mid-stream with out_valid=1 -> out_valid=0 and key stream restarts at 0x01.
- OTP_REKEY_EN with MAX_WORDS=4: after 4 accepts -> exhausted=1 and in_ready=0. seed_load -> RUN, key_count=0, exhausted=0.
